lsu_mem_access: RTL and testbench

Load/store unit between the pipeline MEM stage and the 64-bit data RAM. Takes one RV64 load or store request at a time, issues aligned doubleword RAM accesses, and performs read-modify-write for sub-doubleword stores so the RAM only ever sees full 64-bit writes. Returns sign- or zero-extended load data. Flags misaligned accesses without touching memory.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/lsu_align.sv | 55 +++++
 rtl/lsu_mem_access.sv | 132 +++++++++++++
 tb/tb_lsu_mem_access.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the load/store unit.
//   - funct3 encodings for RV64 loads and stores
//   - lsu_state_t, the load/store FSM state encoding
//   - size_bytes(), access size in bytes from the low funct3 bits
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_t;

    // funct3[1:0] encodes the access size for both signed and unsigned forms.
    function automatic logic [3:0] size_bytes(input logic [1:0] size_code);
        case (size_code)
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane alignment for the load/store unit.
//   word        in  64  doubleword read from RAM
//   wdata       in  64  right-aligned store data
//   offset      in  3   byte offset within the doubleword (addr[2:0])
//   funct3      in  3   RV64 load/store funct3
//   load_data   out 64  extracted and sign/zero-extended load result
//   merged_word out 64  word with the stored bytes replaced by wdata
module lsu_align
    import mem_pkg::*;
(
    input  logic [63:0] word,
    input  logic [63:0] wdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] load_data,
    output logic [63:0] merged_word
);

    logic [63:0] shifted_word;
    logic [63:0] shifted_wdata;
    logic [3:0]  size;
    logic [3:0]  end_byte;

    assign shifted_word  = word >> {offset, 3'b000};
    assign shifted_wdata = wdata << {offset, 3'b000};
    assign size          = size_bytes(funct3[1:0]);
    // One past the last byte written; at most 7 + 8 = 15, fits in 4 bits.
    assign end_byte      = {1'b0, offset} + size;

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{56{shifted_word[7]}},  shifted_word[7:0]};
            F3_H:    load_data = {{48{shifted_word[15]}}, shifted_word[15:0]};
            F3_W:    load_data = {{32{shifted_word[31]}}, shifted_word[31:0]};
            F3_D:    load_data = shifted_word;
            F3_BU:   load_data = {56'd0, shifted_word[7:0]};
            F3_HU:   load_data = {48'd0, shifted_word[15:0]};
            F3_WU:   load_data = {32'd0, shifted_word[31:0]};
            default: load_data = '0;
        endcase
    end

    // Per-byte select: bytes inside [offset, offset+size) take the shifted
    // store data, everything else keeps the old RAM contents.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte
            logic hit;
            assign hit = (4'(gi) >= {1'b0, offset}) && (4'(gi) < end_byte);
            assign merged_word[8*gi +: 8] = hit ? shifted_wdata[8*gi +: 8]
                                                : word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/lsu_mem_access.sv
// lsu_mem_access: RV64 load/store unit between the MEM stage and a 64-bit
// data RAM. One request at a time; sub-doubleword stores are done as
// read-modify-write so the RAM only sees full doubleword writes.
//   clk        in  1       rising-edge clock
//   rst        in  1       asynchronous active-low reset
//   req_valid  in  1       request present
//   req_ready  out 1       high in IDLE only
//   req_we     in  1       1 = store, 0 = load
//   req_funct3 in  3       RV64 load/store funct3
//   req_addr   in  ADDR_W  byte address
//   req_wdata  in  64      right-aligned store data
//   rsp_valid  out 1       response available (RESP state)
//   rsp_ready  in  1       consumer takes the response
//   rsp_rdata  out 64      extended load data; 0 for stores and errors
//   rsp_err    out 1       misaligned access or illegal funct3
//   ram_we     out 1       doubleword write strobe
//   ram_addr   out ADDR_W  doubleword-aligned RAM address
//   ram_wdata  out 64      full merged doubleword
//   ram_rdata  in  64      combinational RAM read data of ram_addr
module lsu_mem_access
    import mem_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [63:0]       ram_wdata,
    input  logic [63:0]       ram_rdata
);

    lsu_state_t        state_reg;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [63:0]       wdata_reg;
    logic [63:0]       word_reg;
    logic              err_reg;

    logic              req_illegal;
    logic              req_misaligned;
    logic              req_bad;
    logic [63:0]       load_data;
    logic [63:0]       merged_word;

    // Request decode, evaluated on the incoming request in IDLE.
    always_comb begin
        req_illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
        case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = |req_addr[1:0];
            2'b11:   req_misaligned = |req_addr[2:0];
            default: req_misaligned = 1'b0;
        endcase
    end

    assign req_bad = req_illegal || req_misaligned;

    lsu_align u_align (
        .word        (word_reg),
        .wdata       (wdata_reg),
        .offset      (addr_reg[2:0]),
        .funct3      (funct3_reg),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            we_reg     <= 1'b0;
            funct3_reg <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            word_reg   <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        we_reg     <= req_we;
                        funct3_reg <= req_funct3;
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata;
                        err_reg    <= req_bad;
                        if (req_bad)
                            state_reg <= S_RESP;
                        else if (req_we && req_funct3 == F3_D)
                            state_reg <= S_WRITE;   // full doubleword, no read needed
                        else
                            state_reg <= S_READ;
                    end
                end
                S_READ: begin
                    word_reg  <= ram_rdata;
                    state_reg <= we_reg ? S_WRITE : S_RESP;
                end
                S_WRITE: begin
                    state_reg <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready)
                        state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // All outputs decode from registered state and latched fields, so they
    // are glitch-free and hold steady for the whole RESP state. Decoding
    // ram_we from state means an async reset in WRITE drops it immediately.
    assign req_ready = (state_reg == S_IDLE);
    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_err   = (state_reg == S_RESP) && err_reg;
    assign rsp_rdata = (state_reg == S_RESP && !err_reg && !we_reg) ? load_data : 64'd0;
    assign ram_we    = (state_reg == S_WRITE);
    assign ram_addr  = {addr_reg[ADDR_W-1:3], 3'b000};
    assign ram_wdata = (funct3_reg == F3_D) ? wdata_reg : merged_word;

endmodule

// File: tb/tb_lsu_mem_access.sv
module tb_lsu_mem_access;
    import mem_pkg::*;

    localparam int ADDR_W = 11;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [63:0]       rsp_rdata;
    logic              rsp_err;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [63:0]       ram_wdata;
    logic [63:0]       ram_rdata;

    lsu_mem_access #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with a preload port; all writes happen in this one process.
    logic [63:0] mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [63:0] pl_data;

    int          cyc = 0;
    int          we_count = 0;
    int          we_cyc = 0;
    logic [63:0] we_data = '0;
    logic [ADDR_W-1:0] we_addr = '0;

    assign ram_rdata = mem[ram_addr[10:3]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) begin
            mem[pl_idx] = pl_data;
        end else if (ram_we) begin
            mem[ram_addr[10:3]] = ram_wdata;
            we_count = we_count + 1;
            we_cyc   = cyc;
            we_data  = ram_wdata;
            we_addr  = ram_addr;
        end
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Results of the most recent transaction.
    logic [63:0] r_rdata;
    logic        r_err;
    int          r_lat;
    int          r_we_n;
    int          r_we_lat;
    int          acc_cyc;
    int          we_base;

    task automatic preload(input logic [7:0] idx, input logic [63:0] d);
        pl_idx  = idx;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    // Present a request, then wait (bounded) for rsp_valid. Latency counts
    // the cycle right after the accept edge as 1.
    task automatic issue_req(input logic we, input logic [2:0] f3,
                             input logic [ADDR_W-1:0] a, input logic [63:0] wd);
        we_base    = we_count;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        acc_cyc    = cyc;
        r_lat      = 1;
        while (!rsp_valid && r_lat < 20) begin
            @(posedge clk); #1;
            r_lat++;
        end
        r_rdata  = rsp_rdata;
        r_err    = rsp_err;
        r_we_n   = we_count - we_base;
        r_we_lat = (r_we_n > 0) ? (we_cyc - acc_cyc + 1) : 0;
    endtask

    task automatic finish_req();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        $display("[TB] %s f3=%0d addr=0x%03h wdata=0x%016h -> rdata=0x%016h err=%0b lat=%0d writes=%0d",
                 req_we ? "ST" : "LD", req_funct3, req_addr, req_wdata, r_rdata, r_err, r_lat, r_we_n);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [ADDR_W-1:0] a, input logic [63:0] wd);
        issue_req(we, f3, a, wd);
        finish_req();
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        pl_en      = 1'b0;
        pl_idx     = '0;
        pl_data    = '0;

        // Preload the RAM model while the DUT is held in reset.
        @(posedge clk); #1;
        preload(8'd1, 64'h0123456789ABCDEF);
        preload(8'd2, 64'h8877665544332211);
        preload(8'd3, 64'h0000000000000000);

        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err",   rsp_err,   0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_ram_we",    ram_we,    0);

        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", req_ready, 1);

        // rsp_ready high while idle must not produce anything.
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_rdy_valid", rsp_valid, 0);
        check("idle_rdy_ready", req_ready, 1);
        rsp_ready = 1'b0;

        // LD aligned
        do_req(1'b0, F3_D, 11'h010, 64'd0);
        check("ld_data",   r_rdata, 64'h8877665544332211);
        check("ld_lat",    r_lat,   2);
        check("ld_writes", r_we_n,  0);
        check("ld_err",    r_err,   0);

        // LB / LBU of the top byte
        do_req(1'b0, F3_B, 11'h017, 64'd0);
        check("lb_data", r_rdata, 64'hFFFFFFFFFFFFFF88);
        do_req(1'b0, F3_BU, 11'h017, 64'd0);
        check("lbu_data", r_rdata, 64'h0000000000000088);
        do_req(1'b0, F3_WU, 11'h014, 64'd0);
        check("lwu_data", r_rdata, 64'h0000000088776655);
        do_req(1'b0, F3_H, 11'h016, 64'd0);
        check("lh_neg_data", r_rdata, 64'hFFFFFFFFFFFF8877);

        // SB read-modify-write
        do_req(1'b1, F3_B, 11'h013, 64'h00000000000000AB);
        check("sb_writes",   r_we_n,   1);
        check("sb_we_lat",   r_we_lat, 2);
        check("sb_wdata",    we_data,  64'h88776655AB332211);
        check("sb_waddr",    we_addr,  11'h010);
        check("sb_lat",      r_lat,    3);
        check("sb_rdata",    r_rdata,  0);
        check("sb_err",      r_err,    0);

        // SW then LW / LD readback
        do_req(1'b1, F3_W, 11'h00C, 64'h00000000DEADBEEF);
        check("sw_wdata", we_data, 64'hDEADBEEF89ABCDEF);
        do_req(1'b0, F3_W, 11'h00C, 64'd0);
        check("lw_data", r_rdata, 64'hFFFFFFFFDEADBEEF);
        do_req(1'b0, F3_D, 11'h008, 64'd0);
        check("sw_lower_kept", r_rdata, 64'hDEADBEEF89ABCDEF);

        // Errors: misaligned LH, misaligned SD, illegal load funct3
        do_req(1'b0, F3_H, 11'h005, 64'd0);
        check("lh_mis_err",    r_err,   1);
        check("lh_mis_lat",    r_lat,   1);
        check("lh_mis_rdata",  r_rdata, 0);
        check("lh_mis_writes", r_we_n,  0);
        do_req(1'b1, F3_D, 11'h009, 64'h1111111111111111);
        check("sd_mis_err",    r_err,   1);
        check("sd_mis_lat",    r_lat,   1);
        check("sd_mis_rdata",  r_rdata, 0);
        check("sd_mis_writes", r_we_n,  0);
        do_req(1'b0, 3'b111, 11'h010, 64'd0);
        check("ld_ill_err",    r_err,   1);
        check("ld_ill_writes", r_we_n,  0);

        // SD aligned: no read phase
        do_req(1'b1, F3_D, 11'h018, 64'h1122334455667788);
        check("sd_lat",    r_lat,    2);
        check("sd_we_lat", r_we_lat, 1);
        check("sd_wdata",  we_data,  64'h1122334455667788);
        check("sd_waddr",  we_addr,  11'h018);
        do_req(1'b0, F3_H, 11'h01E, 64'd0);
        check("lh_pos_data", r_rdata, 64'h0000000000001122);
        do_req(1'b0, F3_HU, 11'h01A, 64'd0);
        check("lhu_data", r_rdata, 64'h0000000000005566);

        // SH with junk in the upper wdata bits: only two bytes may change
        do_req(1'b1, F3_H, 11'h01A, 64'hFFFFFFFFFFFFBEEF);
        check("sh_wdata", we_data, 64'h11223344BEEF7788);

        // Hold the response for 5 cycles
        issue_req(1'b0, F3_D, 11'h010, 64'd0);
        check("hold_first", r_rdata, 64'h88776655AB332211);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, 64'h88776655AB332211);
            check("hold_ready", req_ready, 0);
        end
        finish_req();
        check("hold_back_idle", req_ready, 1);

        // Reset asserted during WRITE of an SB
        we_base    = we_count;
        req_we     = 1'b1;
        req_funct3 = F3_B;
        req_addr   = 11'h018;
        req_wdata  = 64'h00000000000000FF;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        @(posedge clk); #1;
        check("rstw_in_write", ram_we, 1);
        rst = 1'b0;
        #1;
        check("rstw_we_drop", ram_we, 0);
        @(posedge clk); #1;
        check("rstw_mem_kept", mem[3], 64'h11223344BEEF7788);
        check("rstw_no_write", we_count - we_base, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstw_idle_ready", req_ready, 1);
        check("rstw_idle_valid", rsp_valid, 0);
        $display("[TB] ST f3=0 addr=0x018 wdata=0x00000000000000ff -> reset during WRITE");

        do_req(1'b0, F3_D, 11'h018, 64'd0);
        check("post_rst_ld", r_rdata, 64'h11223344BEEF7788);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
